// File: rtl/cordic_angle_seq_pkg.sv
// Shared types and elaboration-time angle table builder for the CORDIC angle sequencer.
// Angles are signed Q2.(WIDTH-2); the builder returns a 64-bit word the caller slices.
package cordic_pkg;

    typedef enum logic [1:0] {
        CIRC = 2'd0,
        HYP  = 2'd1,
        LIN  = 2'd2,
        RSVD = 2'd3
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] HYP_REP0 = 6'd4;
    localparam logic [5:0] HYP_REP1 = 6'd13;
    localparam logic [5:0] HYP_REP2 = 6'd40;

    function automatic logic is_hyp_repeat(input logic [5:0] i);
        return (i == HYP_REP0) || (i == HYP_REP1) || (i == HYP_REP2);
    endfunction

    // Linear entries are exact powers of two; anything under one LSB is zero.
    function automatic logic [63:0] angle_value(input mode_t m, input int unsigned i,
                                                input int unsigned frac);
        real step;
        real scale;
        logic [63:0] v;
        step  = 1.0 / (2.0 ** i);
        scale = 2.0 ** frac;
        v     = '0;
        case (m)
            CIRC: v = 64'(longint'($floor($atan(step) * scale + 0.5)));
            HYP:  if (i != 0) v = 64'(longint'($floor($atanh(step) * scale + 0.5)));
            LIN:  if (i <= frac) v = 64'd1 << (frac - i);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_angle_seq_if.sv
// Beat stream and control bundle between the CORDIC controller, the sequencer and
// the iteration datapath. master = sequencer side.
interface cordic_angle_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic [1:0]       mode_i;
    logic             e_valid_o;
    logic             e_ready_i;
    logic [WIDTH-1:0] e_o;
    logic [5:0]       idx_o;
    logic             last_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport master (
        input  start_i, mode_i, e_ready_i,
        output e_valid_o, e_o, idx_o, last_o, busy_o, done_o, err_o
    );

    modport slave (
        output start_i, mode_i, e_ready_i,
        input  e_valid_o, e_o, idx_o, last_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/cordic_angle_rom.sv
// Combinational (mode, shift index) -> elementary angle lookup.
// Tables are built at elaboration from the package constant function.
module cordic_angle_rom
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  mode_t            mode,
    input  logic [5:0]       idx,
    output logic [WIDTH-1:0] angle
);

    logic [WIDTH-1:0] circ_tab [64];
    logic [WIDTH-1:0] hyp_tab  [64];
    logic [WIDTH-1:0] lin_tab  [64];

    for (genvar g = 0; g < 64; g++) begin : g_tab
        localparam logic [63:0] CIRC_V = angle_value(CIRC, g, WIDTH - 2);
        localparam logic [63:0] HYP_V  = angle_value(HYP,  g, WIDTH - 2);
        localparam logic [63:0] LIN_V  = angle_value(LIN,  g, WIDTH - 2);
        assign circ_tab[g] = CIRC_V[WIDTH-1:0];
        assign hyp_tab[g]  = HYP_V[WIDTH-1:0];
        assign lin_tab[g]  = LIN_V[WIDTH-1:0];
    end

    always_comb begin
        angle = '0;
        case (mode)
            CIRC:    angle = circ_tab[idx];
            HYP:     angle = hyp_tab[idx];
            LIN:     angle = lin_tab[idx];
            default: angle = '0;
        endcase
    end

endmodule

// File: rtl/cordic_angle_seq.sv
// Streams per-iteration CORDIC elementary angles and shift indices for a latched mode,
// with hyperbolic repeat iterations and valid/ready back-pressure.
module cordic_angle_seq
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITERS = 16
) (
    input logic                clk,
    input logic                rst,
    cordic_angle_seq_if.master bus
);

    localparam logic [5:0] LAST = 6'(ITERS - 1);

    state_t           state;
    mode_t            mode;
    logic [5:0]       cnt;
    logic             rep;
    mode_t            nxt_mode;
    logic [5:0]       nxt_idx;
    logic             nxt_rep;
    logic [WIDTH-1:0] rom_angle;

    // Look up the angle of the beat about to be presented so e_o can be registered.
    always_comb begin
        nxt_mode = mode;
        nxt_idx  = bus.idx_o;
        nxt_rep  = 1'b0;
        if (state == IDLE) begin
            nxt_mode = mode_t'(bus.mode_i);
            nxt_idx  = (nxt_mode == HYP) ? 6'd1 : 6'd0;
        end else if (mode == HYP && is_hyp_repeat(bus.idx_o) && !rep) begin
            nxt_rep = 1'b1;
        end else begin
            nxt_idx = bus.idx_o + 6'd1;
        end
    end

    cordic_angle_rom #(
        .WIDTH(WIDTH)
    ) u_rom (
        .mode  (nxt_mode),
        .idx   (nxt_idx),
        .angle (rom_angle)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mode          <= CIRC;
            cnt           <= '0;
            rep           <= 1'b0;
            bus.e_valid_o <= 1'b0;
            bus.e_o       <= '0;
            bus.idx_o     <= '0;
            bus.last_o    <= 1'b0;
            bus.busy_o    <= 1'b0;
            bus.done_o    <= 1'b0;
            bus.err_o     <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            bus.err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (nxt_mode == RSVD) begin
                            bus.err_o <= 1'b1;
                        end else begin
                            state         <= RUN;
                            mode          <= nxt_mode;
                            cnt           <= '0;
                            rep           <= nxt_rep;
                            bus.idx_o     <= nxt_idx;
                            bus.e_o       <= rom_angle;
                            bus.e_valid_o <= 1'b1;
                            bus.busy_o    <= 1'b1;
                            bus.last_o    <= (LAST == 6'd0);
                        end
                    end
                end
                RUN: begin
                    if (bus.e_ready_i) begin
                        if (cnt == LAST) begin
                            state         <= IDLE;
                            bus.e_valid_o <= 1'b0;
                            bus.busy_o    <= 1'b0;
                            bus.last_o    <= 1'b0;
                            bus.done_o    <= 1'b1;
                        end else begin
                            cnt        <= cnt + 6'd1;
                            rep        <= nxt_rep;
                            bus.idx_o  <= nxt_idx;
                            bus.e_o    <= rom_angle;
                            bus.last_o <= (cnt + 6'd1 == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_angle_seq.sv
// Directed bench for cordic_angle_seq: a transaction-level beat-queue model checked
// every cycle, plus hand-computed literal expectations.
module tb_cordic_angle_seq;
    import cordic_pkg::*;

    localparam int W  = 32;
    localparam int W2 = 16;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_angle_seq_if #(.WIDTH(W))  bus  ();
    cordic_angle_seq_if #(.WIDTH(W2)) bus2 ();

    cordic_angle_seq #(.WIDTH(W), .ITERS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cordic_angle_seq #(.WIDTH(W2), .ITERS(N)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected angle from the mathematical definition, at frac fractional bits.
    function automatic logic [63:0] exp_angle(input int m, input int i, input int frac);
        real a;
        real ri;
        real rf;
        ri = i;
        rf = frac;
        case (m)
            0:       a = $atan(1.0 / (2.0 ** ri));
            1:       a = (i == 0) ? 0.0 : $atanh(1.0 / (2.0 ** ri));
            default: a = 1.0 / (2.0 ** ri);
        endcase
        a = a * (2.0 ** rf);
        if (m == 2 && a < 1.0) return 64'd0;
        return 64'(longint'($floor(a + 0.5)));
    endfunction

    typedef struct {
        int           idx;
        logic [W-1:0] e;
        logic         last;
    } beat_t;

    beat_t q[$];
    logic  m_run  = 1'b0;
    logic  m_done = 1'b0;
    logic  m_err  = 1'b0;

    task automatic build_run(input int m);
        int i;
        logic rep;
        beat_t b;
        i   = (m == 1) ? 1 : 0;
        rep = 1'b0;
        q.delete();
        for (int k = 0; k < N; k++) begin
            b.idx  = i;
            b.e    = W'(exp_angle(m, i, W - 2));
            b.last = (k == N - 1);
            q.push_back(b);
            if (m == 1 && (i == 4 || i == 13 || i == 40) && !rep) rep = 1'b1;
            else begin
                i++;
                rep = 1'b0;
            end
        end
    endtask

    // Compare current outputs to the model, then advance it with the inputs the
    // next rising edge will sample.
    always @(negedge clk) begin
        if (rst) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            q.delete();
        end
        chk("m_valid", 64'(bus.e_valid_o), 64'(m_run));
        chk("m_busy",  64'(bus.busy_o),    64'(m_run));
        chk("m_done",  64'(bus.done_o),    64'(m_done));
        chk("m_err",   64'(bus.err_o),     64'(m_err));
        if (m_run) begin
            chk("m_e",    64'(bus.e_o),    64'(q[0].e));
            chk("m_idx",  64'(bus.idx_o),  64'(q[0].idx));
            chk("m_last", 64'(bus.last_o), 64'(q[0].last));
        end
        if (!rst) begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (!m_run) begin
                if (bus.start_i) begin
                    if (bus.mode_i == 2'd3) m_err = 1'b1;
                    else begin
                        build_run(int'(bus.mode_i));
                        m_run = 1'b1;
                    end
                end
            end else if (bus.e_ready_i) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    int           acc;
    int           log_idx[$];
    logic [W-1:0] log_e[$];

    always @(posedge clk) begin
        if (!rst && bus.e_valid_o && bus.e_ready_i) begin
            acc <= acc + 1;
            log_idx.push_back(int'(bus.idx_o));
            log_e.push_back(bus.e_o);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log;
        acc = 0;
        log_idx.delete();
        log_e.delete();
    endtask

    task automatic start_run(input logic [1:0] m);
        bus.mode_i  = m;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int c = 0; c < 60 && !bus.done_o; c++) tick;
        chk(name, 64'(bus.done_o), 64'd1);
    endtask

    int hyp_idx[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};

    initial begin
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.mode_i    = 2'd0;
        bus.e_ready_i = 1'b1;
        bus2.start_i   = 1'b0;
        bus2.mode_i    = 2'd0;
        bus2.e_ready_i = 1'b1;
        acc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.e_valid_o), 64'd0);
        chk("rst_e",     64'(bus.e_o),       64'd0);
        chk("rst_idx",   64'(bus.idx_o),     64'd0);
        chk("rst_last",  64'(bus.last_o),    64'd0);
        chk("rst_busy",  64'(bus.busy_o),    64'd0);
        chk("rst_done",  64'(bus.done_o),    64'd0);
        chk("rst_err",   64'(bus.err_o),     64'd0);
        #1 rst = 1'b0;
        tick;

        // Circular run, with a start request injected mid-run.
        clear_log;
        start_run(2'd0);
        chk("circ_b0_e",   64'(bus.e_o),    64'h3243F6A9);
        chk("circ_b0_idx", 64'(bus.idx_o),  64'd0);
        chk("circ_b0_bsy", 64'(bus.busy_o), 64'd1);
        for (int b = 1; b < N; b++) begin
            tick;
            if (b == 8) begin
                bus.mode_i  = 2'd1;
                bus.start_i = 1'b1;
            end else bus.start_i = 1'b0;
        end
        chk("circ_b15_idx",  64'(bus.idx_o),  64'd15);
        chk("circ_b15_last", 64'(bus.last_o), 64'd1);
        tick;
        chk("circ_done",  64'(bus.done_o),    64'd1);
        chk("circ_valid", 64'(bus.e_valid_o), 64'd0);
        chk("circ_beats", 64'(acc),           64'd16);
        tick;
        chk("circ_done_off", 64'(bus.done_o), 64'd0);

        // Hyperbolic run; mode_i changed mid-run must not matter.
        clear_log;
        start_run(2'd1);
        for (int b = 1; b < N; b++) begin
            tick;
            if (b == 3) bus.mode_i = 2'd2;
        end
        tick;
        chk("hyp_done",  64'(bus.done_o),     64'd1);
        chk("hyp_count", 64'(log_idx.size()), 64'd16);
        if (log_idx.size() == 16) begin
            for (int k = 0; k < 16; k++) chk("hyp_idx_seq", 64'(log_idx[k]), 64'(hyp_idx[k]));
            chk("hyp_rep4_a", 64'(log_e[3]), exp_angle(1, 4, 30));
            chk("hyp_rep4_b", 64'(log_e[4]), exp_angle(1, 4, 30));
        end
        tick;

        // Linear run on both widths.
        clear_log;
        bus2.mode_i  = 2'd2;
        bus2.start_i = 1'b1;
        start_run(2'd2);
        bus2.start_i = 1'b0;
        chk("lin_b0_e",    64'(bus.e_o),  64'h40000000);
        chk("lin16_b0_e",  64'(bus2.e_o), 64'h4000);
        for (int b = 1; b < N; b++) begin
            tick;
            if (b == 3)  chk("lin_b3_e",    64'(bus.e_o),  64'h08000000);
            if (b == 14) chk("lin16_b14_e", 64'(bus2.e_o), 64'h0001);
            if (b == 15) begin
                chk("lin16_b15_e",   64'(bus2.e_o),   64'h0000);
                chk("lin16_b15_idx", 64'(bus2.idx_o), 64'd15);
            end
        end
        tick;
        chk("lin_done",   64'(bus.done_o),  64'd1);
        chk("lin16_done", 64'(bus2.done_o), 64'd1);
        tick;

        // Back-pressure: stall three cycles while beat 5 is presented.
        clear_log;
        start_run(2'd0);
        repeat (5) tick;
        bus.e_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick;
            chk("bp_hold_e",    64'(bus.e_o),       exp_angle(0, 5, 30));
            chk("bp_hold_idx",  64'(bus.idx_o),     64'd5);
            chk("bp_hold_last", 64'(bus.last_o),    64'd0);
            chk("bp_hold_vld",  64'(bus.e_valid_o), 64'd1);
        end
        bus.e_ready_i = 1'b1;
        tick;
        chk("bp_b6_idx", 64'(bus.idx_o), 64'd6);
        wait_done("bp_done");
        chk("bp_beats", 64'(acc), 64'd16);
        tick;

        // Reserved mode is rejected.
        bus.mode_i  = 2'd3;
        bus.start_i = 1'b1;
        tick;
        bus.start_i = 1'b0;
        chk("err_pulse", 64'(bus.err_o),     64'd1);
        chk("err_busy",  64'(bus.busy_o),    64'd0);
        chk("err_valid", 64'(bus.e_valid_o), 64'd0);
        tick;
        chk("err_off", 64'(bus.err_o), 64'd0);

        // Asynchronous reset at beat 7, then a fresh run.
        start_run(2'd0);
        repeat (7) tick;
        chk("rr_b7_idx", 64'(bus.idx_o), 64'd7);
        #1 rst = 1'b1;
        #1;
        chk("rr_valid", 64'(bus.e_valid_o), 64'd0);
        chk("rr_e",     64'(bus.e_o),       64'd0);
        chk("rr_idx",   64'(bus.idx_o),     64'd0);
        chk("rr_last",  64'(bus.last_o),    64'd0);
        chk("rr_busy",  64'(bus.busy_o),    64'd0);
        chk("rr_done",  64'(bus.done_o),    64'd0);
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("rr_no_done", 64'(bus.done_o), 64'd0);
        clear_log;
        start_run(2'd0);
        chk("rr_new_idx", 64'(bus.idx_o), 64'd0);
        chk("rr_new_e",   64'(bus.e_o),   64'h3243F6A9);
        wait_done("rr_new_done");
        chk("rr_new_beats", 64'(acc), 64'd16);
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_angle_seq.md
# cordic_angle_seq

Parametrised, sequenced successor to the CORDIC di/ei angle LUT. On a start request it latches a rotation mode (circular, hyperbolic or linear) and streams the per-iteration elementary angles e_i together with their shift index, one per handshake beat. It handles the hyperbolic repeat iterations and downstream back-pressure. It sits between the CORDIC controller and the iteration datapath, which consumes one e_i per micro-rotation.

## Interface
- WIDTH, 32, angle word width in bits, 16..64; format signed Q2.(WIDTH-2), so 1.0 = 2^(WIDTH-2)
- ITERS, 16, iterations (beats) per run, 1..48
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  run request; sampled only in IDLE
- mode_i  in  2  0=circular, 1=hyperbolic, 2=linear, 3=reserved
- e_valid_o  out  1  e_o/idx_o/last_o are valid
- e_ready_i  in  1  consumer accepts the current beat
- e_o  out  WIDTH  elementary angle for this beat
- idx_o  out  6  shift amount i for this beat
- last_o  out  1  current beat is beat ITERS-1
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse after the last beat is accepted
- err_o  out  1  one-cycle pulse when start_i arrives with mode_i=3

## Operation
- The FSM has two states, IDLE and RUN. All outputs are registered.
- IDLE with start_i=1 and mode_i in {0,1,2}:
  - latch mode_i
  - clear beat counter
  - load the first index: 0 for circular/linear, 1 for hyperbolic
  - go to RUN
- IDLE with start_i=1 and mode_i=3: pulse err_o and stay in IDLE.
- RUN asserts e_valid_o. A beat advances only on e_valid_o && e_ready_i. Otherwise all outputs hold stable.
- Angle values, each rounded to nearest:
  - circular: atan(2^-i)
  - hyperbolic: atanh(2^-i)
  - linear: 2^-i; values below 1 LSB give 0
- Index progression:
  - circular/linear: i increments by 1 per beat.
  - hyperbolic: i=4, 13 and 40 are each emitted twice in succession (repeat flag), then i increments.
- Beat counter runs 0..ITERS-1. last_o = (counter == ITERS-1).
- Acceptance of the last beat: go to IDLE, deassert e_valid_o and busy_o, pulse done_o next cycle.
- start_i in RUN is ignored. A new run needs IDLE, so at least one idle cycle follows done_o.
- mode_i is ignored outside IDLE; the latched mode governs the whole run.
- rst at any time, including mid-run, aborts immediately: IDLE, no done_o.

## Timing
- Reset values: e_valid_o=0, e_o=0, idx_o=0, last_o=0, busy_o=0, done_o=0, err_o=0; state IDLE.
- start_i sampled high at edge N: busy_o and e_valid_o high after edge N, carrying beat 0.
- With e_ready_i held high: one beat per cycle, so a run spans ITERS cycles of e_valid_o.
- Last beat accepted at edge M: after edge M, e_valid_o=0 and done_o=1 for exactly one cycle.
- err_o is asserted for the cycle after the offending edge.

## Structure
- Package cordic_pkg holds:
  - mode_t enum (CIRC, HYP, LIN, RSVD)
  - constant function building the per-mode angle tables at elaboration ($atan/$atanh, WIDTH-2 fractional bits, round to nearest)
  - hyperbolic repeat-index constants 4, 13, 40
- Sub-module cordic_angle_rom: combinational (mode, idx) -> angle lookup. cordic_angle_seq registers its output.

## Test plan
- Circular, WIDTH=32, ITERS=16, ready=1: start -> 16 consecutive beats.
  - beat 0: e_o=0x3243F6A9, idx_o=0
  - beat 15: idx_o=15, last_o=1
  - done_o pulses on the following cycle
- Hyperbolic, ITERS=16: idx_o sequence is exactly 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14.
  - e_o at both idx 4 beats equals round(atanh(1/16)*2^30)
- Linear, WIDTH=32: beat 0 e_o=0x40000000, beat 3 e_o=0x08000000. With WIDTH=16, ITERS=16: beats with i>=15 give e_o=0.
- Back-pressure: deassert e_ready_i for 3 cycles at beat 5 -> e_o, idx_o, last_o held stable. Beat 6 appears only after the acceptance cycle; total beats still 16.
- Rejection:
  - start_i during RUN: no effect, sequence uninterrupted
  - start_i with mode_i=3 in IDLE: err_o one cycle, busy_o stays 0
- Reset mid-run at beat 7 -> all outputs 0 immediately (asynchronous), no done_o. A fresh start afterwards begins at beat 0.
